usb_fs_rx_phy: RTL

//  Full-speed USB receive front end for the CDC device top level. Recovers bits from the

---
 rtl/usb_fs_rx_phy_if.sv | 18 +
 rtl/usb_fs_rx_phy.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_rx_phy_if.sv
// Receive-side byte stream from the USB FS PHY to the packet decoder; err_count exists only with USB_RX_ERR_COUNT_EN.
// Strobe-only: no ready, the consumer must take every rx_valid/rx_eop/rx_err pulse.
interface usb_fs_rx_phy_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_eop;
    logic       rx_err;
`ifdef USB_RX_ERR_COUNT_EN
    logic [7:0] err_count;

    modport master (output rx_data, rx_valid, rx_active, rx_eop, rx_err, err_count);
    modport slave  (input  rx_data, rx_valid, rx_active, rx_eop, rx_err, err_count);
`else
    modport master (output rx_data, rx_valid, rx_active, rx_eop, rx_err);
    modport slave  (input  rx_data, rx_valid, rx_active, rx_eop, rx_err);
`endif
endinterface

// File: rtl/usb_fs_rx_phy.sv
// USB FS receive PHY: SYNC detect, bit recovery, NRZI decode, destuff, EOP check (USB_RX_ERR_COUNT_EN adds err_count).
// Strobes land 1 clk after the deciding bit sample; no backpressure, every strobe must be consumed.
module usb_fs_rx_phy #(
    parameter int OVERSAMPLE   = 4,
    parameter int SYNC_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dp_in,
    input  logic            dn_in,
    input  logic            tx_active,
    usb_fs_rx_phy_if.master rx
);
    localparam int            PW        = $clog2(OVERSAMPLE);
    localparam int            SW        = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [PW-1:0] SAMPLE_PH = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [1:0]    LS_J      = 2'b10;
    localparam logic [1:0]    LS_K      = 2'b01;
    localparam logic [1:0]    LS_SE0    = 2'b00;

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ABORT} state_t;

    logic          dp_m, dp_s, dn_m, dn_s;
    logic [1:0]    ls, ls_q, prev_samp;
    logic [PW-1:0] phase;
    logic          change, bit_stb, is_se0, is_j, dbit;

    state_t        state, state_d;
    logic [SW-1:0] sync_cnt, sync_cnt_d;
    logic [2:0]    ones, ones_d;
    logic [2:0]    bit_cnt, bit_cnt_d;
    logic [7:0]    shreg, shreg_d;
    logic          se0_2, se0_2_d;
    logic          partial, partial_d;
    logic          j_seen, j_seen_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d, eop_q, eop_d, err_q, err_d, active_q, active_d;

    // (1,1) is folded into SE0 so only a clean differential state counts as J or K
    assign ls      = (dp_s ^ dn_s) ? {dp_s, dn_s} : LS_SE0;
    assign change  = (ls != ls_q);
    assign bit_stb = (phase == SAMPLE_PH) && !change;
    assign is_se0  = (ls == LS_SE0);
    assign is_j    = (ls == LS_J);
    assign dbit    = (ls == prev_samp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_m      <= 1'b0;
            dp_s      <= 1'b0;
            dn_m      <= 1'b0;
            dn_s      <= 1'b0;
            ls_q      <= LS_SE0;
            prev_samp <= LS_SE0;
            phase     <= '0;
        end else begin
            dp_m      <= dp_in;
            dp_s      <= dp_m;
            dn_m      <= dn_in;
            dn_s      <= dn_m;
            ls_q      <= ls;
            phase     <= change ? '0 : phase + PW'(1);
            if (bit_stb) prev_samp <= ls;
        end
    end

    always_comb begin
        state_d    = state;
        sync_cnt_d = sync_cnt;
        ones_d     = ones;
        bit_cnt_d  = bit_cnt;
        shreg_d    = shreg;
        se0_2_d    = se0_2;
        partial_d  = partial;
        j_seen_d   = j_seen;
        data_d     = data_q;
        valid_d    = 1'b0;
        eop_d      = 1'b0;
        err_d      = 1'b0;
        case (state)
            S_IDLE: begin
                if (change && ls_q == LS_J && ls == LS_K) begin
                    state_d    = S_SYNC;
                    sync_cnt_d = '0;
                end
            end
            S_SYNC: begin
                if (bit_stb) begin
                    if (is_se0) begin
                        state_d = S_IDLE;
                    end else if (dbit) begin
                        state_d   = S_DATA;
                        ones_d    = '0;
                        bit_cnt_d = '0;
                    end else if (sync_cnt == SW'(SYNC_TIMEOUT - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        sync_cnt_d = sync_cnt + SW'(1);
                    end
                end
            end
            S_DATA: begin
                if (bit_stb) begin
                    if (is_se0) begin
                        state_d   = S_EOP;
                        se0_2_d   = 1'b0;
                        partial_d = (bit_cnt != 3'd0);
                    end else if (ones == 3'd6) begin
                        if (dbit) begin
                            err_d    = 1'b1;
                            state_d  = S_ABORT;
                            j_seen_d = 1'b0;
                        end else begin
                            ones_d = '0;
                        end
                    end else begin
                        shreg_d   = {dbit, shreg[7:1]};
                        bit_cnt_d = bit_cnt + 3'd1;
                        ones_d    = dbit ? ones + 3'd1 : 3'd0;
                        if (bit_cnt == 3'd7) begin
                            valid_d = 1'b1;
                            data_d  = shreg_d;
                        end
                    end
                end
            end
            S_EOP: begin
                if (bit_stb) begin
                    if (!se0_2) begin
                        if (is_se0) begin
                            se0_2_d = 1'b1;
                        end else begin
                            err_d    = 1'b1;
                            state_d  = S_ABORT;
                            j_seen_d = 1'b0;
                        end
                    end else if (is_j) begin
                        state_d = S_IDLE;
                        err_d   = partial;
                        eop_d   = !partial;
                    end else if (!is_se0) begin
                        err_d    = 1'b1;
                        state_d  = S_ABORT;
                        j_seen_d = 1'b0;
                    end
                end
            end
            S_ABORT: begin
                if (bit_stb) begin
                    if (!is_j)       j_seen_d = 1'b0;
                    else if (j_seen) state_d  = S_IDLE;
                    else             j_seen_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Own transmission masks the receiver, including anything decided this cycle
        if (tx_active) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            eop_d   = 1'b0;
            err_d   = 1'b0;
            data_d  = data_q;
        end
        active_d = (state_d == S_DATA) || (state_d == S_EOP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sync_cnt <= '0;
            ones     <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            se0_2    <= 1'b0;
            partial  <= 1'b0;
            j_seen   <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            eop_q    <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state    <= state_d;
            sync_cnt <= sync_cnt_d;
            ones     <= ones_d;
            bit_cnt  <= bit_cnt_d;
            shreg    <= shreg_d;
            se0_2    <= se0_2_d;
            partial  <= partial_d;
            j_seen   <= j_seen_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            eop_q    <= eop_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

    assign rx.rx_data   = data_q;
    assign rx.rx_valid  = valid_q;
    assign rx.rx_eop    = eop_q;
    assign rx.rx_err    = err_q;
    assign rx.rx_active = active_q;

`ifdef USB_RX_ERR_COUNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         err_cnt <= '0;
        else if (err_d && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end

    assign rx.err_count = err_cnt;
`endif
endmodule
